// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore controller for the shared-memory multi-cycle MIPS datapath.
//            Decodes the latched opcode/funct fields and sequences mux selects,
//            write enables and ALU operation, one instruction at a time, with
//            a single-port memory ready handshake for fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  // State encodings (visible on the debug state port)
  localparam logic [3:0] C_FETCH   = 4'd0;
  localparam logic [3:0] C_DECODE  = 4'd1;
  localparam logic [3:0] C_MEMADR  = 4'd2;
  localparam logic [3:0] C_MEMRD   = 4'd3;
  localparam logic [3:0] C_MEMWB   = 4'd4;
  localparam logic [3:0] C_MEMWR   = 4'd5;
  localparam logic [3:0] C_EXEC    = 4'd6;
  localparam logic [3:0] C_ALUWB   = 4'd7;
  localparam logic [3:0] C_BEQ     = 4'd8;
  localparam logic [3:0] C_ADDIEX  = 4'd9;
  localparam logic [3:0] C_ADDIWB  = 4'd10;
  localparam logic [3:0] C_JUMP    = 4'd11;
  localparam logic [3:0] C_ILLEGAL = 4'd12;

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  // ALU B input selects
  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR = 2'b01;
  localparam logic [1:0] C_SRCB_IMM  = 2'b10;
  localparam logic [1:0] C_SRCB_IMM4 = 2'b11;

  // Next-PC selects
  localparam logic [1:0] C_PC_ALU    = 2'b00;
  localparam logic [1:0] C_PC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PC_JUMP   = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       r_is_lw;

  // Internal (pre-reset-gating) control values
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_alucontrol;
  logic [1:0] w_pcsrc;
  logic       w_instr_done;
  logic       w_illegal;

  logic       w_funct_ok;
  logic [2:0] w_funct_alu;

  // Map the R-type funct field to its ALU operation and flag unsupported ones
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = C_ALU_ADD;
    case (funct)
      C_FN_ADD: w_funct_alu = C_ALU_ADD;
      C_FN_SUB: w_funct_alu = C_ALU_SUB;
      C_FN_AND: w_funct_alu = C_ALU_AND;
      C_FN_OR:  w_funct_alu = C_ALU_OR;
      C_FN_SLT: w_funct_alu = C_ALU_SLT;
      default: begin
        w_funct_ok  = 1'b0;
        w_funct_alu = C_ALU_ADD;
      end
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Remember lw vs sw at decode so op is only consulted in DECODE/EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_lw <= 1'b0;
    end else if (r_state == C_DECODE) begin
      r_is_lw <= (op == C_OP_LW);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_FETCH: begin
        if (mem_ready) begin
          w_next_state = C_DECODE;
        end
      end
      C_DECODE: begin
        case (op)
          C_OP_LW, C_OP_SW: w_next_state = C_MEMADR;
          C_OP_RTYPE:       w_next_state = w_funct_ok ? C_EXEC : C_ILLEGAL;
          C_OP_BEQ:         w_next_state = C_BEQ;
          C_OP_ADDI:        w_next_state = C_ADDIEX;
          C_OP_J:           w_next_state = C_JUMP;
          default:          w_next_state = C_ILLEGAL;
        endcase
      end
      C_MEMADR:  w_next_state = r_is_lw ? C_MEMRD : C_MEMWR;
      C_MEMRD: begin
        if (mem_ready) begin
          w_next_state = C_MEMWB;
        end
      end
      C_MEMWB:   w_next_state = C_FETCH;
      C_MEMWR: begin
        if (mem_ready) begin
          w_next_state = C_FETCH;
        end
      end
      C_EXEC:    w_next_state = C_ALUWB;
      C_ALUWB:   w_next_state = C_FETCH;
      C_BEQ:     w_next_state = C_FETCH;
      C_ADDIEX:  w_next_state = C_ADDIWB;
      C_ADDIWB:  w_next_state = C_FETCH;
      C_JUMP:    w_next_state = C_FETCH;
      C_ILLEGAL: w_next_state = C_ILLEGAL;
      default:   w_next_state = C_FETCH;
    endcase
  end

  // Per-state control outputs; anything not set stays 0, ALU defaults to add
  always_comb begin
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_iord       = 1'b0;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = C_SRCB_REG;
    w_alucontrol = C_ALU_ADD;
    w_pcsrc      = C_PC_ALU;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      C_FETCH: begin
        w_iord    = 1'b0;
        w_memread = 1'b1;
        w_alusrca = 1'b0;
        w_alusrcb = C_SRCB_FOUR;
        w_pcsrc   = C_PC_ALU;
        // PC and IR load only on the cycle the instruction word arrives
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      C_DECODE: begin
        w_alusrca = 1'b0;
        w_alusrcb = C_SRCB_IMM4;
      end
      C_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = C_SRCB_IMM;
      end
      C_MEMRD: begin
        w_iord    = 1'b1;
        w_memread = 1'b1;
      end
      C_MEMWB: begin
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      C_MEMWR: begin
        w_iord       = 1'b1;
        w_memwrite   = 1'b1;
        w_instr_done = mem_ready;
      end
      C_EXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = C_SRCB_REG;
        w_alucontrol = w_funct_alu;
      end
      C_ALUWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      C_BEQ: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = C_SRCB_REG;
        w_alucontrol = C_ALU_SUB;
        w_branch     = 1'b1;
        w_pcsrc      = C_PC_ALUOUT;
        w_instr_done = 1'b1;
      end
      C_ADDIEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = C_SRCB_IMM;
        w_alucontrol = C_ALU_ADD;
      end
      C_ADDIWB: begin
        w_regdst     = 1'b0;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      C_JUMP: begin
        w_pcsrc      = C_PC_JUMP;
        w_pcwrite    = 1'b1;
        w_instr_done = 1'b1;
      end
      C_ILLEGAL: begin
        w_illegal = 1'b1;
      end
      default: begin
        // Unreachable encodings drive everything, ALU op included, to 0
        w_alucontrol = 3'b000;
      end
    endcase
  end

  // Reset forces every output low at once, including the FETCH memory request
  assign PCWrite    = w_pcwrite    & ~rst;
  assign Branch     = w_branch     & ~rst;
  assign IorD       = w_iord       & ~rst;
  assign MemRead    = w_memread    & ~rst;
  assign MemWrite   = w_memwrite   & ~rst;
  assign IRWrite    = w_irwrite    & ~rst;
  assign RegDst     = w_regdst     & ~rst;
  assign MemtoReg   = w_memtoreg   & ~rst;
  assign RegWrite   = w_regwrite   & ~rst;
  assign ALUSrcA    = w_alusrca    & ~rst;
  assign ALUSrcB    = w_alusrcb    & {2{~rst}};
  assign ALUControl = w_alucontrol & {3{~rst}};
  assign PCSrc      = w_pcsrc      & {2{~rst}};
  assign instr_done = w_instr_done & ~rst;
  assign illegal    = w_illegal    & ~rst;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Purpose  : Self-checking bench for mips_multicycle_ctrl: directed vector
//            table, instruction-level random run against a step-list model,
//            and hand sequences for illegal decode and mid-instruction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       instr_done, illegal;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic done, ill;
  } ctl_t;

  typedef struct {
    logic       r;
    logic [5:0] o;
    logic [5:0] f;
    logic       mr;
    logic [3:0] st;
    logic [6:0] key;   // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal}
    logic [2:0] aluc;
    logic [1:0] pcsrc;
  } vec_t;

  logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_rw, cnt_pcw, cnt_irw, cnt_done;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = '{state, PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst,
          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal};
    return c;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    logic [2:0] a;
    a = 3'bxxx;
    for (int i = 0; i < 5; i++) if (fn_tab[i] == fn) a = alu_tab[i];
    return a;
  endfunction

  // Expected outputs for one step of an instruction, from the state table
  function automatic ctl_t model_ctl(input int s, input logic mr, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    c.st = 4'(s);
    c.aluc = 3'b010;
    case (s)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.iord = 1; c.mrd = 1; end
      4:  begin c.m2r = 1; c.rw = 1; c.done = 1; end
      5:  begin c.iord = 1; c.mwr = 1; c.done = mr; end
      6:  begin c.srca = 1; c.aluc = alu_of(fn); end
      7:  begin c.rdst = 1; c.rw = 1; c.done = 1; end
      8:  begin c.srca = 1; c.aluc = 3'b110; c.br = 1; c.pcsrc = 2'b01; c.done = 1; end
      9:  begin c.srca = 1; c.srcb = 2'b10; end
      10: begin c.rw = 1; c.done = 1; end
      11: begin c.pcsrc = 2'b10; c.pcw = 1; c.done = 1; end
      12: c.ill = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check before the rise
  task automatic do_cycle(input logic mr, input logic [5:0] o, input logic [5:0] f,
                          input ctl_t exp, input string name);
    @(negedge clk);
    op = o; funct = f; mem_ready = mr;
    #1;
    check(name, {9'd0, dut_ctl()}, {9'd0, exp});
    cnt_rw   += int'(RegWrite);
    cnt_pcw  += int'(PCWrite);
    cnt_irw  += int'(IRWrite);
    cnt_done += int'(instr_done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    check("reset", {9'd0, dut_ctl()}, 32'd0);
    @(negedge clk);
    #1;
    check("reset_hold", {9'd0, dut_ctl()}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Run a whole instruction as its list of steps, with random memory waits
  task automatic run_instr(input int kind, input int maxwait);
    int steps[$];
    logic [5:0] o, f;
    logic mr;
    int w, exp_rw, exp_pcw;
    f = 6'($urandom);
    case (kind)
      0: begin o = 6'b100011; steps = '{0, 1, 2, 3, 4}; end
      1: begin o = 6'b101011; steps = '{0, 1, 2, 5}; end
      2, 3, 4, 5, 6: begin o = 6'b000000; f = fn_tab[kind-2]; steps = '{0, 1, 6, 7}; end
      7: begin o = 6'b000100; steps = '{0, 1, 8}; end
      8: begin o = 6'b001000; steps = '{0, 1, 9, 10}; end
      default: begin o = 6'b000010; steps = '{0, 1, 11}; end
    endcase
    cnt_rw = 0; cnt_pcw = 0; cnt_irw = 0; cnt_done = 0;
    foreach (steps[i]) begin
      if (steps[i] == 0 || steps[i] == 3 || steps[i] == 5) begin
        w = $urandom_range(0, maxwait);
        for (int k = 0; k <= w; k++) begin
          mr = (k == w);
          do_cycle(mr, o, f, model_ctl(steps[i], mr, f),
                   $sformatf("rnd k%0d s%0d", kind, steps[i]));
        end
      end else begin
        mr = 1'($urandom);
        do_cycle(mr, o, f, model_ctl(steps[i], mr, f),
                 $sformatf("rnd k%0d s%0d", kind, steps[i]));
      end
    end
    exp_rw  = (kind == 1 || kind == 7 || kind == 9) ? 0 : 1;
    exp_pcw = (kind == 9) ? 2 : 1;
    check($sformatf("regwrite_count k%0d", kind), 32'(cnt_rw), 32'(exp_rw));
    check($sformatf("pcwrite_count k%0d", kind), 32'(cnt_pcw), 32'(exp_pcw));
    check($sformatf("irwrite_count k%0d", kind), 32'(cnt_irw), 32'd1);
    check($sformatf("done_count k%0d", kind), 32'(cnt_done), 32'd1);
  endtask

  task automatic add_v(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic mr, input logic [3:0] st, input logic [6:0] key,
                       input logic [2:0] aluc, input logic [1:0] pcsrc);
    vec_t v;
    v.r = r; v.o = o; v.f = f; v.mr = mr; v.st = st;
    v.key = key; v.aluc = aluc; v.pcsrc = pcsrc;
    vq.push_back(v);
  endtask

  initial begin
    logic [15:0] got, exp;

    // ---------------- Directed vector table ----------------
    add_v(1, 6'h23, 6'h00, 1, 4'd0,  7'b0000000, 3'b000, 2'b00);  // reset
    add_v(0, 6'h23, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);  // lw fetch
    add_v(0, 6'h23, 6'h00, 0, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h23, 6'h00, 1, 4'd2,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h23, 6'h00, 1, 4'd3,  7'b0010000, 3'b010, 2'b00);
    add_v(0, 6'h23, 6'h00, 0, 4'd4,  7'b0000110, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 0, 4'd0,  7'b0010000, 3'b010, 2'b00);  // sw, fetch wait
    add_v(0, 6'h2B, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 1, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 1, 4'd2,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 0, 4'd5,  7'b0001000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 0, 4'd5,  7'b0001000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 0, 4'd5,  7'b0001000, 3'b010, 2'b00);
    add_v(0, 6'h2B, 6'h00, 1, 4'd5,  7'b0001010, 3'b010, 2'b00);
    for (int i = 0; i < 5; i++) begin                               // R-types
      add_v(0, 6'h00, fn_tab[i], 1, 4'd0, 7'b1110000, 3'b010, 2'b00);
      add_v(0, 6'h00, fn_tab[i], 1, 4'd1, 7'b0000000, 3'b010, 2'b00);
      add_v(0, 6'h00, fn_tab[i], 1, 4'd6, 7'b0000000, alu_tab[i], 2'b00);
      add_v(0, 6'h00, fn_tab[i], 1, 4'd7, 7'b0000110, 3'b010, 2'b00);
    end
    add_v(0, 6'h04, 6'h3F, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);  // beq
    add_v(0, 6'h04, 6'h3F, 1, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h04, 6'h3F, 1, 4'd8,  7'b0000010, 3'b110, 2'b01);
    add_v(0, 6'h02, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);  // j
    add_v(0, 6'h02, 6'h00, 1, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h02, 6'h00, 0, 4'd11, 7'b1000010, 3'b010, 2'b10);
    add_v(0, 6'h08, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);  // addi
    add_v(0, 6'h08, 6'h00, 1, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h08, 6'h00, 1, 4'd9,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h08, 6'h00, 1, 4'd10, 7'b0000110, 3'b010, 2'b00);
    add_v(0, 6'h3F, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);  // illegal op
    add_v(0, 6'h3F, 6'h00, 1, 4'd1,  7'b0000000, 3'b010, 2'b00);
    add_v(0, 6'h3F, 6'h00, 1, 4'd12, 7'b0000001, 3'b010, 2'b00);
    add_v(0, 6'h23, 6'h00, 1, 4'd12, 7'b0000001, 3'b010, 2'b00);
    add_v(1, 6'h23, 6'h00, 1, 4'd0,  7'b0000000, 3'b000, 2'b00);  // reset clears
    add_v(0, 6'h23, 6'h00, 1, 4'd0,  7'b1110000, 3'b010, 2'b00);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; op = vq[i].o; funct = vq[i].f; mem_ready = vq[i].mr;
      #1;
      got = {state, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done,
             illegal, ALUControl, PCSrc};
      exp = {vq[i].st, vq[i].key, vq[i].aluc, vq[i].pcsrc};
      check($sformatf("vec[%0d]", i), {16'd0, got}, {16'd0, exp});
    end

    // ---------------- Random instruction stream ----------------
    do_reset();
    repeat (80) run_instr($urandom_range(0, 9), 3);
    repeat (10) run_instr($urandom_range(0, 9), 0);

    // ---------------- Illegal decodes absorb until reset ----------------
    for (int t = 0; t < 2; t++) begin
      logic [5:0] io, ifn;
      io  = (t == 0) ? 6'b111111 : 6'b000000;
      ifn = 6'b000000;
      do_reset();
      do_cycle(1'b1, io, ifn, model_ctl(0, 1'b1, ifn), "ill_fetch");
      do_cycle(1'b1, io, ifn, model_ctl(1, 1'b1, ifn), "ill_decode");
      for (int k = 0; k < 20; k++)
        do_cycle(1'($urandom), 6'($urandom), 6'($urandom), model_ctl(12, 1'b0, 6'd0),
                 $sformatf("ill_hold t%0d", t));
    end
    do_reset();
    run_instr(0, 2);

    // ---------------- Reset during a stalled MEMRD ----------------
    cnt_rw = 0;
    do_cycle(1'b1, 6'b100011, 6'd0, model_ctl(0, 1'b1, 6'd0), "ar_fetch");
    do_cycle(1'b0, 6'b100011, 6'd0, model_ctl(1, 1'b0, 6'd0), "ar_decode");
    do_cycle(1'b0, 6'b100011, 6'd0, model_ctl(2, 1'b0, 6'd0), "ar_memadr");
    do_cycle(1'b0, 6'b100011, 6'd0, model_ctl(3, 1'b0, 6'd0), "ar_memrd");
    #1 rst = 1'b1;
    #1 check("async_rst", {9'd0, dut_ctl()}, 32'd0);
    cnt_rw += int'(RegWrite);
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("async_rst_hold", {9'd0, dut_ctl()}, 32'd0);
      cnt_rw += int'(RegWrite);
    end
    check("async_rst_no_regwrite", 32'(cnt_rw), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(2, 1);
    run_instr(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore finite-state controller that sequences the shared-memory multi-cycle MIPS datapath, one instruction at a time. It decodes the latched opcode and funct fields and drives every datapath mux select, write enable and ALU operation for each step. It waits on a single-port memory handshake for instruction fetch and for data access. It sits beside the datapath in the CPU top level and replaces the combinational single-cycle decoder.

## Interface
Parameters: none.

Ports (all control outputs are 1 bit unless a width is given):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode from the instruction register (IR[31:26]).
- funct  in  6  function field from the instruction register (IR[5:0]).
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load; the datapath gates it with the ALU Zero flag.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write-register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write-data select: 0 = ALUOut, 1 = memory data register.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUControl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  an unsupported instruction was decoded.
- state  out  4  current state encoding, for debug.

## Operation
- Any output not listed for a state is 0. ALUControl defaults to 010.
- State encodings:
  - 0 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11 (precomputes the branch target). Next state by op:
    - 100011 or 101011 → MEMADR
    - 000000 with a supported funct → EXEC
    - 000100 → BEQ
    - 001000 → ADDIEX
    - 000010 → JUMP
    - anything else → ILLEGAL
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD for lw (op 100011), MEMWR for sw.
  - 3 MEMRD: IorD=1, MemRead=1. Waits for mem_ready, then → MEMWB.
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. → FETCH.
  - 5 MEMWR: IorD=1, MemWrite=1, held for the whole wait. instr_done=mem_ready. → FETCH on mem_ready.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. → ALUWB.
  - 7 ALUWB: RegDst=1, RegWrite=1, instr_done=1. → FETCH.
  - 8 BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1, PCSrc=01, instr_done=1. → FETCH.
  - 9 ADDIEX: ALUSrcA=1, ALUSrcB=10, add. → ADDIWB.
  - 10 ADDIWB: RegDst=0, RegWrite=1, instr_done=1. → FETCH.
  - 11 JUMP: PCSrc=10, PCWrite=1, instr_done=1. → FETCH.
  - 12 ILLEGAL: illegal=1. Absorbing; only reset exits it.
- Unused encodings 13–15 go to FETCH on the next edge with all outputs 0.
- op and funct are sampled only in DECODE and EXEC. They must be stable there because the IR is loaded only in FETCH.

## Timing
- While rst=1: state=0, and every output is 0, including MemRead. The first FETCH request appears in the cycle after rst deasserts.
- Reset asserted mid-instruction aborts it immediately. No further RegWrite, MemWrite or PCWrite is issued for that instruction.
- Cycles per instruction with zero wait (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR. Control outputs stay constant throughout the wait.
- PCWrite and IRWrite are asserted for exactly one cycle per fetch, the mem_ready cycle. RegWrite is asserted for exactly one cycle per writing instruction.
- mem_ready is ignored in all states except FETCH, MEMRD and MEMWR.

## Test plan
- Reset with mem_ready=1, then run lw (op 100011) → states 0,1,2,3,4,0. Exactly one RegWrite, with MemtoReg=1 and RegDst=0. instr_done high in cycle 5.
- sw with mem_ready held low for 3 cycles in MEMWR → MemWrite=1 and IorD=1 for 4 cycles, instr_done pulses once, RegWrite never asserted.
- R-type slt (funct 101010) → ALUControl=111 in EXEC, RegDst=1 in ALUWB, 4 cycles total. Repeat for add, sub, and, or, checking encodings 010, 110, 000, 001.
- beq, then j, back to back → Branch=1, PCSrc=01, ALUControl=110 in cycle 3. Then PCWrite=1, PCSrc=10 in the j's cycle 3. PCWrite pulses exactly twice per fetch/jump as specified.
- op=111111, then R-type with funct=000000 → both go DECODE→ILLEGAL and hold illegal=1 for 20 cycles. rst clears it to state 0 with all outputs 0.
- Assert rst during MEMRD with mem_ready low → asynchronous return to state 0, outputs 0 immediately. No RegWrite occurs; normal fetch resumes after deassert.
